// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps sel through the enabled channels in
// ascending order, dwells on each, captures mux_out and pulses done.
module mux4_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [1:0]         sel,
  output logic               busy,
  output logic               done,
  output logic [3:0]         sample,
  output logic               sample_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_e;

  state_e             state_q;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] count_q;
  logic [1:0]         sel_q;
  logic               busy_q;
  logic               done_q;
  logic [3:0]         sample_q;
  logic               valid_q;

  logic               first_found_d;
  logic [1:0]         first_ch_d;
  logic               next_found_d;
  logic [1:0]         next_ch_d;

  // Descending scan so the lowest qualifying channel is the last one written.
  // NOTE: every comb output gets a default first, so no latch is inferred.
  always_comb begin
    first_found_d = 1'b0;
    first_ch_d    = 2'd0;
    next_found_d  = 1'b0;
    next_ch_d     = sel_q;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_found_d = 1'b1;
        first_ch_d    = 2'(i);
      end
      if (mask_q[i] && (2'(i) > sel_q)) begin
        next_found_d = 1'b1;
        next_ch_d    = 2'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      dwell_q  <= '0;
      count_q  <= '0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 4'b0;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q   <= ch_mask;
            dwell_q  <= dwell;
            sample_q <= 4'b0;
            if (first_found_d) begin
              sel_q   <= first_ch_d;
              count_q <= dwell;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
              state_q <= SETTLE;
            end else begin
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        SETTLE: begin
          if (count_q != '0) count_q <= count_q - DWELL_W'(1);
          else               state_q <= CAPTURE;
        end
        CAPTURE: begin
          sample_q[sel_q] <= mux_out;
          if (next_found_d) begin
            sel_q   <= next_ch_d;
            count_q <= dwell_q;
            state_q <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: directed scans plus random traffic, all checked
// cycle by cycle against a per-scan expected trace.
module tb_mux4_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] ch_mask;
  logic [3:0] dwell;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;
  logic       sample_valid;
  logic [3:0] in_vec;

  int errors = 0;
  int checks = 0;

  mux4_scan_ctrl #(.DWELL_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ch_mask      (ch_mask),
    .dwell        (dwell),
    .mux_out      (mux_out),
    .sel          (sel),
    .busy         (busy),
    .done         (done),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  assign mux_out = in_vec[sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       cap;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [3:0] pend;
  logic [3:0] exp_sample;
  logic       exp_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A scan is a list of per-cycle expectations: dwell+1 settle cycles and one
  // capture cycle per enabled channel, then a single done cycle.
  task automatic build_scan(input logic [3:0] m, input logic [3:0] d, input logic [1:0] prev_sel);
    logic [1:0] last;
    last = prev_sel;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        repeat (int'(d) + 1) exp_q.push_back('{2'(i), 1'b1, 1'b0, 1'b0});
        exp_q.push_back('{2'(i), 1'b1, 1'b0, 1'b1});
        last = 2'(i);
      end
    end
    exp_q.push_back('{last, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic model_edge();
    if (rst) begin
      exp_q.delete();
      cur        = '{2'd0, 1'b0, 1'b0, 1'b0};
      pend       = 4'b0;
      exp_sample = 4'b0;
      exp_valid  = 1'b0;
    end else begin
      if (cur.cap) pend[cur.sel] = in_vec[cur.sel];
      if (exp_q.size() == 0 && !cur.done && start) begin
        pend       = 4'b0;
        exp_sample = 4'b0;
        exp_valid  = 1'b0;
        build_scan(ch_mask, dwell, cur.sel);
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.done) begin
          exp_sample = pend;
          exp_valid  = 1'b1;
        end
      end else begin
        cur = '{cur.sel, 1'b0, 1'b0, 1'b0};
      end
    end
  endtask

  task automatic check_all();
    check("sel", sel, cur.sel);
    check("busy", busy, cur.busy);
    check("done", done, cur.done);
    check("sample_valid", sample_valid, exp_valid);
    if (exp_q.size() == 0) check("sample", sample, exp_sample);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Start a scan and count cycles until done, bounded.
  task automatic scan(input logic [3:0] iv, input logic [3:0] m, input logic [3:0] d,
                      input int exp_lat, input string tag);
    int n;
    in_vec  = iv;
    ch_mask = m;
    dwell   = d;
    start   = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      step();
      n++;
    end
    check(tag, n, exp_lat);
    step();
    step();
  endtask

  initial begin
    int n;
    int dcount;
    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = 4'b0;
    dwell   = 4'b0;
    in_vec  = 4'b0;
    cur     = '{2'd0, 1'b0, 1'b0, 1'b0};
    pend    = 4'b0;
    exp_sample = 4'b0;
    exp_valid  = 1'b0;

    // Reset with random inputs, start included: reset must win.
    repeat (2) begin
      start   = 1'($urandom);
      ch_mask = 4'($urandom);
      dwell   = 4'($urandom);
      in_vec  = 4'($urandom);
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    step();

    scan(4'b1010, 4'b1111, 4'd0, 9, "lat_full_mask");
    check("sample_full", sample, 4'b1010);
    scan(4'b0111, 4'b0101, 4'd2, 9, "lat_sparse");
    check("sample_sparse", sample, 4'b0101);
    scan(4'b1111, 4'b0000, 4'd5, 1, "lat_empty_mask");
    check("sample_empty", sample, 4'b0000);
    check("valid_empty", sample_valid, 1'b1);
    scan(4'b1000, 4'b1000, 4'hF, 18, "lat_max_dwell");
    check("sample_max_dwell", sample, 4'b1000);

    // Mid-scan start pulse and mask change are ignored.
    in_vec  = 4'b0110;
    ch_mask = 4'b1111;
    dwell   = 4'd3;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    start   = 1'b1;
    ch_mask = 4'b0001;
    dwell   = 4'd0;
    step();
    start = 1'b0;
    n = 5;
    while (!done && n < 60) begin
      step();
      n++;
    end
    check("lat_ignore_start", n, 21);
    check("sample_ignore_start", sample, 4'b0110);
    step();

    // Reset mid-scan: no done pulse afterwards.
    ch_mask = 4'b1111;
    dwell   = 4'd3;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dcount = 0;
    repeat (25) begin
      step();
      if (done) dcount++;
    end
    check("no_done_after_rst", dcount, 0);

    // Random traffic, including stray starts, mask churn and rare resets.
    repeat (1500) begin
      rst     = ($urandom_range(99) == 0);
      start   = ($urandom_range(3) == 0);
      ch_mask = 4'($urandom);
      dwell   = ($urandom_range(9) == 0) ? 4'($urandom) : 4'($urandom_range(3));
      in_vec  = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
